seg_display_arbiter: RTL and testbench

//   Shares the 8-digit multiplexed 7-segment driver between 4 requesters (e.g. clock, timer,

---
 rtl/seg_display_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin owner selection for a shared 8-digit 7-segment driver, with a minimum dwell per grant.
// Optional blinking of the owner's frame is compiled in with SEG_ARB_BLINK_EN.
module seg_display_arbiter #(
  parameter logic [15:0] HOLD_TICKS = 16'd50000,
  parameter logic [15:0] BLINK_HALF = 16'd25000,
  parameter logic [7:0]  BLANK      = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [63:0] frame0,
  input  logic [63:0] frame1,
  input  logic [63:0] frame2,
  input  logic [63:0] frame3,
  input  logic [3:0]  blink,
  output logic [3:0]  grant,
  output logic        busy,
  output logic        switch_pulse,
  output logic [7:0]  o0,
  output logic [7:0]  o1,
  output logic [7:0]  o2,
  output logic [7:0]  o3,
  output logic [7:0]  o4,
  output logic [7:0]  o5,
  output logic [7:0]  o6,
  output logic [7:0]  o7
);

  localparam logic [15:0] HOLD_EFF_C  = (HOLD_TICKS == 16'd0) ? 16'd1 : HOLD_TICKS;
  localparam logic [15:0] HOLD_LAST_C = HOLD_EFF_C - 16'd1;
  localparam logic [63:0] BLANK_ALL_C = {8{BLANK}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OPEN = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  grant_r;
  logic        busy_r;
  logic        switch_pulse_r;
  logic [1:0]  rr_last_r;
  logic [15:0] hold_cnt_r;
  logic [63:0] disp_r;

  logic [3:0]  cand_s;
  logic [2:0]  pick_s;
  logic        owner_req_s;
  logic        take_s;
  logic [63:0] frame_sel_s;
  logic        visible_s;

  // Scan last+1, last+2, ... (mod 4); the lowest offset that is a candidate wins. Returns {valid, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (cand[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Arbitration candidates, the round-robin winner and whether a new grant is taken this edge.
  always_comb begin
    cand_s      = 4'b0000;
    pick_s      = 3'b000;
    owner_req_s = |(req & grant_r);
    take_s      = 1'b0;
    if (state_r == ST_IDLE) begin
      cand_s = req;
    end else begin
      cand_s = req & ~grant_r;
    end
    pick_s = rr_pick(cand_s, rr_last_r);
    case (state_r)
      ST_IDLE: take_s = pick_s[2];
      ST_HOLD: take_s = pick_s[2] && owner_req_s && (hold_cnt_r == HOLD_LAST_C);
      ST_OPEN: take_s = pick_s[2] && owner_req_s;
      default: take_s = 1'b0;
    endcase
  end

  // Grant FSM: an owner drop always wins over a competing request in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      grant_r        <= 4'b0000;
      busy_r         <= 1'b0;
      switch_pulse_r <= 1'b0;
      rr_last_r      <= 2'd3;
      hold_cnt_r     <= 16'd0;
    end else begin
      switch_pulse_r <= 1'b0;
      if (take_s) begin
        grant_r        <= onehot(pick_s[1:0]);
        busy_r         <= 1'b1;
        rr_last_r      <= pick_s[1:0];
        hold_cnt_r     <= 16'd0;
        switch_pulse_r <= 1'b1;
        state_r        <= ST_HOLD;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_HOLD: begin
            if (!owner_req_s) begin
              grant_r    <= 4'b0000;
              busy_r     <= 1'b0;
              hold_cnt_r <= 16'd0;
              state_r    <= ST_IDLE;
            end else if (hold_cnt_r == HOLD_LAST_C) begin
              hold_cnt_r <= sat_inc(hold_cnt_r);
              state_r    <= ST_OPEN;
            end else begin
              hold_cnt_r <= hold_cnt_r + 16'd1;
            end
          end
          ST_OPEN: begin
            if (!owner_req_s) begin
              grant_r    <= 4'b0000;
              busy_r     <= 1'b0;
              hold_cnt_r <= 16'd0;
              state_r    <= ST_IDLE;
            end else begin
              hold_cnt_r <= sat_inc(hold_cnt_r);
            end
          end
          default: begin
            grant_r <= 4'b0000;
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Frame belonging to the current owner; blank when idle.
  always_comb begin
    frame_sel_s = BLANK_ALL_C;
    case (grant_r)
      4'b0001: frame_sel_s = frame0;
      4'b0010: frame_sel_s = frame1;
      4'b0100: frame_sel_s = frame2;
      4'b1000: frame_sel_s = frame3;
      default: frame_sel_s = BLANK_ALL_C;
    endcase
  end

`ifdef SEG_ARB_BLINK_EN
  localparam logic [15:0] BLINK_EFF_C  = (BLINK_HALF == 16'd0) ? 16'd1 : BLINK_HALF;
  localparam logic [15:0] BLINK_LAST_C = BLINK_EFF_C - 16'd1;

  logic [15:0] blink_cnt_r;
  logic        blink_hidden_r;

  // Blink phase restarts visible on every new grant and runs only while someone owns the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_r    <= 16'd0;
      blink_hidden_r <= 1'b0;
    end else if (take_s) begin
      blink_cnt_r    <= 16'd0;
      blink_hidden_r <= 1'b0;
    end else if (grant_r != 4'b0000) begin
      if (blink_cnt_r == BLINK_LAST_C) begin
        blink_cnt_r    <= 16'd0;
        blink_hidden_r <= ~blink_hidden_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + 16'd1;
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  // Hidden phase only matters when the owner itself asks to blink.
  always_comb begin
    visible_s = 1'b1;
    if ((|(blink & grant_r)) && blink_hidden_r) begin
      visible_s = 1'b0;
    end else begin
      visible_s = 1'b1;
    end
  end
`else
  logic blink_unused_s;

  // Blinking is not built in: the frame is always shown.
  always_comb begin
    visible_s = 1'b1;
  end

  assign blink_unused_s = ^{blink, BLINK_HALF};
`endif

  // Digit outputs trail the grant by one cycle and follow live frame updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r <= BLANK_ALL_C;
    end else if (visible_s) begin
      disp_r <= frame_sel_s;
    end else begin
      disp_r <= BLANK_ALL_C;
    end
  end

  assign grant        = grant_r;
  assign busy         = busy_r;
  assign switch_pulse = switch_pulse_r;
  assign o0 = disp_r[63:56];
  assign o1 = disp_r[55:48];
  assign o2 = disp_r[47:40];
  assign o3 = disp_r[39:32];
  assign o4 = disp_r[31:24];
  assign o5 = disp_r[23:16];
  assign o6 = disp_r[15:8];
  assign o7 = disp_r[7:0];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed plus randomized bench for seg_display_arbiter against an owner/age reference model.
// Blink expectations are modelled when SEG_ARB_BLINK_EN is defined.
module tb_seg_display_arbiter;

  localparam logic [15:0] HT = 16'd4;
  localparam logic [15:0] BH = 16'd3;
  localparam logic [63:0] ALL_BLANK = {8{8'hFF}};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  blink;
  logic [63:0] frame0, frame1, frame2, frame3;
  logic [3:0]  grant;
  logic        busy, switch_pulse;
  logic [7:0]  o0, o1, o2, o3, o4, o5, o6, o7;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 idle), edges since grant, last winner.
  int          m_owner;
  int          m_age;
  int          m_last;
  logic        m_pulse;
  logic [63:0] m_o;

  seg_display_arbiter #(.HOLD_TICKS(HT), .BLINK_HALF(BH), .BLANK(8'hFF)) dut (
    .clk(clk), .rst(rst), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2), .frame3(frame3),
    .blink(blink), .grant(grant), .busy(busy), .switch_pulse(switch_pulse),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] frame_of(input int k);
    case (k)
      0: return frame0;
      1: return frame1;
      2: return frame2;
      default: return frame3;
    endcase
  endfunction

  function automatic logic [63:0] dut_o();
    return {o0, o1, o2, o3, o4, o5, o6, o7};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Apply the arbitration rules to the inputs sampled at this edge.
  task automatic model_update();
    int win;
    int idx;
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = 3; m_pulse = 1'b0; m_o = ALL_BLANK;
    end else begin
      if (m_owner < 0) begin
        m_o = ALL_BLANK;
      end else begin
        m_o = frame_of(m_owner);
`ifdef SEG_ARB_BLINK_EN
        if (blink[m_owner] && (((m_age / int'(BH)) % 2) == 1)) m_o = ALL_BLANK;
`endif
      end
      m_pulse = 1'b0;
      if (m_owner >= 0) m_age++;
      if (m_owner >= 0 && !req[m_owner]) begin
        m_owner = -1;
      end else if (m_owner < 0 || m_age >= int'(HT)) begin
        win = -1;
        for (int i = 1; i <= 4; i++) begin
          idx = (m_last + i) % 4;
          if (win < 0 && req[idx] && idx != m_owner) win = idx;
        end
        if (win >= 0) begin
          m_owner = win; m_last = win; m_age = 0; m_pulse = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    logic [3:0] eg;
    @(posedge clk);
    model_update();
    #1;
    eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("grant", {60'd0, grant}, {60'd0, eg});
    chk("busy", {63'd0, busy}, {63'd0, (m_owner >= 0)});
    chk("switch_pulse", {63'd0, switch_pulse}, {63'd0, m_pulse});
    chk("digits", dut_o(), m_o);
  endtask

  initial begin
    int pulses;
    m_owner = -1; m_age = 0; m_last = 3; m_pulse = 1'b0; m_o = ALL_BLANK;
    rst = 1'b1; req = 4'b1111; blink = 4'b0000;
    frame0 = 64'h0011223344556677; frame1 = 64'h1111111111111111;
    frame2 = 64'h2222222222222222; frame3 = 64'h3333333333333333;

    // Reset held with all requests asserted
    tick(); tick();
    chk("rst_grant", {60'd0, grant}, 64'd0);
    chk("rst_digits", dut_o(), ALL_BLANK);

    // Single requester 0
    rst = 1'b0; req = 4'b0001;
    tick();
    chk("t2_grant", {60'd0, grant}, 64'd1);
    chk("t2_pulse", {63'd0, switch_pulse}, 64'd1);
    tick();
    chk("t2_digits", dut_o(), 64'h0011223344556677);

    // Requester 1 arrives during owner 0's dwell
    req = 4'b0011;
    tick(); tick();
    chk("t3_still0", {60'd0, grant}, 64'd1);
    tick();
    chk("t3_now1", {60'd0, grant}, 64'd2);

    // All four requesting: rotation with a pulse per grant
    req = 4'b1111;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (switch_pulse) pulses++;
    end
    chk("t4_pulses", 64'(pulses), 64'd4);

    // Owner 2 drops during dwell while requester 0 waits
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0100; tick();
    chk("t5_own2", {60'd0, grant}, 64'd4);
    req = 4'b0101; tick();
    req = 4'b0001; tick();
    chk("t5_idle", {60'd0, grant}, 64'd0);
    tick();
    chk("t5_regrant", {60'd0, grant}, 64'd1);
    chk("t5_blank", dut_o(), ALL_BLANK);

    // Lone owner with blink request held long enough to reach open state
    blink = 4'b0001;
    for (int i = 0; i < 14; i++) tick();
    blink = 4'b0000;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
      end
      if ($urandom_range(0, 15) == 0) blink = 4'($urandom);
      if ($urandom_range(0, 7) == 0) frame0 = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) frame1 = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) frame2 = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) frame3 = {$urandom, $urandom};
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
